// File: rtl/universal_register_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : universal_register_pkg
//  Description : Shared definitions for the universal register: control
//                width, opcode encodings and the opcode enum type.
//                Optional feature macro: UNIVERSAL_REGISTER_ROTATE_EN
//                (opcode 7 becomes ROTATE_RIGHT when defined).
//  Revision    : 1.0 - initial release
// ============================================================================
package universal_register_pkg;

    localparam int CTRL_W = 3;

    localparam logic [CTRL_W-1:0] NONE                = 3'd0;
    localparam logic [CTRL_W-1:0] CLR                 = 3'd1;
    localparam logic [CTRL_W-1:0] PARALLEL_LOAD       = 3'd2;
    localparam logic [CTRL_W-1:0] SERIAL_MSB_LOAD     = 3'd3;
    localparam logic [CTRL_W-1:0] SERIAL_LSB_LOAD     = 3'd4;
    localparam logic [CTRL_W-1:0] SHIFT_LOGICAL_LEFT  = 3'd5;
    localparam logic [CTRL_W-1:0] SHIFT_LOGICAL_RIGHT = 3'd6;
    localparam logic [CTRL_W-1:0] ROTATE_RIGHT        = 3'd7;

    typedef enum logic [CTRL_W-1:0] {
        OP_NONE                = NONE,
        OP_CLR                 = CLR,
        OP_PARALLEL_LOAD       = PARALLEL_LOAD,
        OP_SERIAL_MSB_LOAD     = SERIAL_MSB_LOAD,
        OP_SERIAL_LSB_LOAD     = SERIAL_LSB_LOAD,
        OP_SHIFT_LOGICAL_LEFT  = SHIFT_LOGICAL_LEFT,
        OP_SHIFT_LOGICAL_RIGHT = SHIFT_LOGICAL_RIGHT,
        OP_ROTATE_RIGHT        = ROTATE_RIGHT
    } opcode_e;

endpackage : universal_register_pkg
`default_nettype wire

// File: rtl/universal_register_next.sv
`default_nettype none
// ============================================================================
//  Module      : universal_register_next
//  Description : Purely combinational next-state selector for the universal
//                register. Optional feature macro: UNIVERSAL_REGISTER_ROTATE_EN.
//  Ports       : ctrl                - opcode (CTRL_W bits)
//                q                   - current register contents
//                serial_data_input   - bit inserted by serial loads
//                parallel_data_input - value for parallel load
//                q_next              - value to be registered
//  Revision    : 1.0 - initial release
// ============================================================================
module universal_register_next
    import universal_register_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [CTRL_W-1:0] ctrl,
    input  logic [WIDTH-1:0]  q,
    input  logic              serial_data_input,
    input  logic [WIDTH-1:0]  parallel_data_input,
    output logic [WIDTH-1:0]  q_next
);

    always_comb begin
        q_next = q;
        case (ctrl)
            NONE:                q_next = q;
            // Clear is unconditionally zero; it never follows RESET_VALUE.
            CLR:                 q_next = '0;
            PARALLEL_LOAD:       q_next = parallel_data_input;
            SERIAL_MSB_LOAD:     q_next = {serial_data_input, q[WIDTH-1:1]};
            SERIAL_LSB_LOAD:     q_next = {q[WIDTH-2:0], serial_data_input};
            SHIFT_LOGICAL_LEFT:  q_next = {q[WIDTH-2:0], 1'b0};
            SHIFT_LOGICAL_RIGHT: q_next = {1'b0, q[WIDTH-1:1]};
`ifdef UNIVERSAL_REGISTER_ROTATE_EN
            ROTATE_RIGHT:        q_next = {q[0], q[WIDTH-1:1]};
`endif
            // Reserved opcode 7 (feature disabled) and unknown ctrl hold.
            default:             q_next = q;
        endcase
    end

endmodule : universal_register_next
`default_nettype wire

// File: rtl/universal_register.sv
`default_nettype none
// ============================================================================
//  Module      : universal_register
//  Description : Parameterised universal register: hold, clear, parallel
//                load, serial load from either end and logical shifts.
//                Optional feature macro: UNIVERSAL_REGISTER_ROTATE_EN
//                (opcode 7 = rotate right; otherwise opcode 7 holds).
//  Ports       : clk                 - rising-edge clock
//                async_nreset        - active-low reset, sampled on clk only
//                ctrl                - opcode select
//                serial_data_input   - serial-load bit
//                parallel_data_input - parallel-load value
//                data_output         - register contents (flop output)
//  Revision    : 1.0 - initial release
// ============================================================================
module universal_register
    import universal_register_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic              clk,
    input  logic              async_nreset,
    input  logic [CTRL_W-1:0] ctrl,
    input  logic              serial_data_input,
    input  logic [WIDTH-1:0]  parallel_data_input,
    output logic [WIDTH-1:0]  data_output
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_next;

    universal_register_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .ctrl                (ctrl),
        .q                   (r_q),
        .serial_data_input   (serial_data_input),
        .parallel_data_input (parallel_data_input),
        .q_next              (w_q_next)
    );

    // Despite its name the reset is synchronous: it is only seen at a
    // rising clock edge, and it overrides every opcode.
    always_ff @(posedge clk) begin
        if (!async_nreset) begin
            r_q <= RESET_VALUE;
        end else begin
            r_q <= w_q_next;
        end
    end

    assign data_output = r_q;

endmodule : universal_register
`default_nettype wire

// File: tb/tb_universal_register.sv
`default_nettype none
// ============================================================================
//  Module      : tb_universal_register
//  Description : Self-checking bench for universal_register (WIDTH=8).
//                Expected values are queued as stimulus is applied and
//                popped after the following rising edge.
//                Honours UNIVERSAL_REGISTER_ROTATE_EN for opcode 7.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_universal_register;
    import universal_register_pkg::*;

    localparam int WIDTH = 8;

    logic              clk;
    logic              async_nreset;
    logic [CTRL_W-1:0] ctrl;
    logic              serial_data_input;
    logic [WIDTH-1:0]  parallel_data_input;
    logic [WIDTH-1:0]  data_output;

    int n_assert;
    int n_fail;

    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] model_q;

    universal_register #(
        .WIDTH       (WIDTH),
        .RESET_VALUE ({WIDTH{1'b0}})
    ) dut (
        .clk                 (clk),
        .async_nreset        (async_nreset),
        .ctrl                (ctrl),
        .serial_data_input   (serial_data_input),
        .parallel_data_input (parallel_data_input),
        .data_output         (data_output)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] ref_next(input logic rstn,
                                                  input logic [2:0] c,
                                                  input logic s,
                                                  input logic [WIDTH-1:0] p,
                                                  input logic [WIDTH-1:0] m);
        if (!rstn) return '0;
        case (c)
            3'd1:    return '0;
            3'd2:    return p;
            3'd3:    return {s, m[WIDTH-1:1]};
            3'd4:    return {m[WIDTH-2:0], s};
            3'd5:    return {m[WIDTH-2:0], 1'b0};
            3'd6:    return {1'b0, m[WIDTH-1:1]};
`ifdef UNIVERSAL_REGISTER_ROTATE_EN
            3'd7:    return {m[0], m[WIDTH-1:1]};
`endif
            default: return m;
        endcase
    endfunction

    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive one cycle, queue the expected value, then pop and compare it
    // after the edge. The model is kept in step so random ops can follow.
    task automatic step(input string tag, input logic rstn, input logic [2:0] c,
                        input logic s, input logic [WIDTH-1:0] p,
                        input logic [WIDTH-1:0] exp);
        logic [WIDTH-1:0] e;
        async_nreset        = rstn;
        ctrl                = c;
        serial_data_input   = s;
        parallel_data_input = p;
        exp_q.push_back(exp);
        model_q = exp;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, data_output, exp);
        end else begin
            e = exp_q.pop_front();
            check(tag, data_output, e);
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        model_q  = '0;
        async_nreset        = 1'b0;
        ctrl                = '0;
        serial_data_input   = 1'b0;
        parallel_data_input = '0;
        @(posedge clk);
        #1;

        // Reset with random ctrl/data
        for (int i = 0; i < 3; i++) begin
            step("reset_hold", 1'b0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)), 8'h00);
        end
        step("release_hold", 1'b1, NONE, 1'b1, 8'hFF, 8'h00);

        // Parallel then MSB serial load
        step("parallel_load", 1'b1, PARALLEL_LOAD, 1'b0, 8'b0000_1111, 8'b0000_1111);
        step("serial_msb",    1'b1, SERIAL_MSB_LOAD, 1'b1, 8'hAA, 8'b1000_0111);

        // LSB serial load and logical shifts
        step("serial_lsb",    1'b1, SERIAL_LSB_LOAD, 1'b1, 8'h55, 8'b0000_1111);
        step("shift_left",    1'b1, SHIFT_LOGICAL_LEFT, 1'b1, 8'hFF, 8'b0001_1110);
        step("shift_right_1", 1'b1, SHIFT_LOGICAL_RIGHT, 1'b1, 8'hFF, 8'b0000_1111);
        step("shift_right_2", 1'b1, SHIFT_LOGICAL_RIGHT, 1'b1, 8'hFF, 8'b0000_0111);

        // Hold and clear from A5
        step("load_a5", 1'b1, PARALLEL_LOAD, 1'b0, 8'hA5, 8'hA5);
        step("hold_1",  1'b1, NONE, 1'b1, 8'h5A, 8'hA5);
        step("hold_2",  1'b1, NONE, 1'b0, 8'hFF, 8'hA5);
        step("hold_3",  1'b1, NONE, 1'b1, 8'h00, 8'hA5);
        step("clear",   1'b1, CLR, 1'b1, 8'hFF, 8'h00);

        // Reset priority and no effect before the edge
        step("load_ff", 1'b1, PARALLEL_LOAD, 1'b0, 8'hFF, 8'hFF);
        async_nreset        = 1'b0;
        ctrl                = PARALLEL_LOAD;
        parallel_data_input = 8'h3C;
        #3;
        check("midcycle_reset_no_effect", data_output, 8'hFF);
        step("reset_priority", 1'b0, PARALLEL_LOAD, 1'b0, 8'h3C, 8'h00);

        // Opcode 7 from 0000_0001
        step("load_01", 1'b1, PARALLEL_LOAD, 1'b0, 8'h01, 8'h01);
`ifdef UNIVERSAL_REGISTER_ROTATE_EN
        step("opcode7_rotate", 1'b1, ROTATE_RIGHT, 1'b1, 8'hFF, 8'b1000_0000);
`else
        step("opcode7_hold",   1'b1, ROTATE_RIGHT, 1'b1, 8'hFF, 8'b0000_0001);
`endif

        // Random operations against the reference model
        for (int i = 0; i < 60; i++) begin
            logic            r_rstn;
            logic [2:0]      r_c;
            logic            r_s;
            logic [WIDTH-1:0] r_p;
            r_rstn = ($urandom_range(0, 15) != 0);
            r_c    = 3'($urandom_range(0, 7));
            r_s    = 1'($urandom_range(0, 1));
            r_p    = 8'($urandom_range(0, 255));
            step("random_op", r_rstn, r_c, r_s, r_p,
                 ref_next(r_rstn, r_c, r_s, r_p, model_q));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_universal_register
`default_nettype wire

// File: doc/universal_register.md
Name: universal_register

Overview:
- Parameterised universal storage register: hold, clear, parallel load, serial load from either end, and logical shift left/right.
- Selected by a 3-bit opcode, updated on the rising clock edge.
- General-purpose datapath building block for accumulators, serialisers/deserialisers and shift-based arithmetic.
- Contents are always visible on a parallel output.

Parameters:
- WIDTH, 8, register width in bits; legal range ≥ 2.
- RESET_VALUE, {WIDTH{1'b0}}, value loaded on reset.

Ports:
- clk  input  1  rising-edge clock.
- async_nreset  input  1  reset, active-low. Sampled synchronously on rising clk only; the port name is kept for codebase consistency.
- ctrl  input  3  operation select (opcodes below).
- serial_data_input  input  1  bit inserted by the serial-load operations.
- parallel_data_input  input  WIDTH  value for parallel load.
- data_output  output  WIDTH  current register contents (direct flop output, no combinational path from inputs).

Behaviour:
- Single register q[WIDTH-1:0]; data_output = q at all times.
- Reset: at rising clk with async_nreset=0, q <= RESET_VALUE (default all zeros). Reset has priority over every ctrl value. Deassertion takes effect at the first rising edge that samples async_nreset=1.
- Latency: one cycle. The ctrl and data values sampled at edge N are visible on data_output immediately after edge N.
- Opcodes, evaluated at each rising clk when not in reset:
  - 0 NONE: q <= q.
  - 1 CLR: q <= 0. This is always zero, independent of RESET_VALUE.
  - 2 PARALLEL_LOAD: q <= parallel_data_input.
  - 3 SERIAL_MSB_LOAD: shift right, serial bit enters MSB: q <= {serial_data_input, q[WIDTH-1:1]}; old q[0] is discarded.
  - 4 SERIAL_LSB_LOAD: shift left, serial bit enters LSB: q <= {q[WIDTH-2:0], serial_data_input}; old MSB is discarded.
  - 5 SHIFT_LOGICAL_LEFT: q <= {q[WIDTH-2:0], 1'b0}.
  - 6 SHIFT_LOGICAL_RIGHT: q <= {1'b0, q[WIDTH-1:1]}.
  - 7: reserved; hold (q <= q) unless the optional feature below is enabled.
- Unused inputs are ignored for the current opcode: serial_data_input outside opcodes 3/4, parallel_data_input outside opcode 2.
- X/unknown ctrl: not defined for synthesis. The RTL implements the opcode decode as a full case with a default of hold.
- No handshakes, no status outputs, no combinational loops.

Optional Feature:
- Macro UNIVERSAL_REGISTER_ROTATE_EN.
- Defined: opcode 7 = ROTATE_RIGHT, q <= {q[0], q[WIDTH-1:1]}.
- Not defined: opcode 7 holds (identical to NONE).
- All other opcodes are identical in both builds.

Decomposition:
- Package universal_register_pkg holds:
  - CTRL_W = 3.
  - Opcode localparams NONE, CLR, PARALLEL_LOAD, SERIAL_MSB_LOAD, SERIAL_LSB_LOAD, SHIFT_LOGICAL_LEFT, SHIFT_LOGICAL_RIGHT, ROTATE_RIGHT (values 0–7).
  - An opcode enum typedef.
- Benches import the same package.
- One natural sub-module: universal_register_next, a purely combinational next-state mux (ctrl, q, serial_data_input, parallel_data_input → q_next). The top level holds only the flop and reset.

Test Plan (WIDTH=8):
- Reset: hold async_nreset=0 for 2+ edges with random ctrl/data → data_output=8'h00. Release → still 8'h00 until the first non-hold opcode.
- Parallel then MSB serial load: parallel_data_input=8'b0000_1111, ctrl=2 → 8'b0000_1111. Next edge serial_data_input=1, ctrl=3 → 8'b1000_0111.
- LSB serial load and logical shifts, starting from 8'b1000_0111:
  - ctrl=4, serial=1 → 8'b0000_1111.
  - ctrl=5 → 8'b0001_1110.
  - ctrl=6 twice → 8'b0000_0111.
- Hold and clear from 8'hA5:
  - ctrl=0 for 3 cycles with toggling data inputs → stays 8'hA5.
  - ctrl=1 → 8'h00.
- Reset priority: load 8'hFF, then assert async_nreset=0 together with ctrl=2 and parallel_data_input=8'h3C → 8'h00. Mid-cycle reset assertion does not change the output before the next rising edge.
- Opcode 7 from 8'b0000_0001:
  - Without the macro → unchanged.
  - With UNIVERSAL_REGISTER_ROTATE_EN → 8'b1000_0000.
